memory_arbiter: RTL and testbench

Shares the single byte-addressed data memory unit between the instruction-fetch stage and the data-memory stage. Each cycle it grants one requester, formats the access code, byte enables and store data for the memory unit, and tracks the one-cycle synchronous read latency. It returns load data to the correct requester, with size-dependent sign or zero extension. The block sits between the pipeline and the memory unit.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_load_align.sv | 27 ++
 rtl/memory_arbiter.sv | 117 +++++++++++
 tb/tb_memory_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: access sizes, byte enables,
// access-code field positions and read-owner identifiers.
package mem_arb_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HALF = 4'b1100;
    localparam logic [3:0] BE_BYTE = 4'b1000;

    localparam int AC_STORE_BIT = 4;
    localparam int AC_BE_MSB    = 3;
    localparam int AC_BE_LSB    = 0;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } owner_e;

    // Size 2'b11 is deliberately folded onto the word encoding.
    function automatic logic [3:0] size_to_be(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return BE_BYTE;
            SIZE_HALF: return BE_HALF;
            default:   return BE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword from the
// top of the memory word and sign- or zero-extends it; zero latency.
module mem_load_align
    import mem_arb_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] data
);

    logic fill_byte;
    logic fill_half;

    assign fill_byte = !zero_ext && raw[31];
    assign fill_half = !zero_ext && raw[31];

    always_comb begin
        data = raw;
        case (size)
            SIZE_BYTE: data = {{24{fill_byte}}, raw[31:24]};
            SIZE_HALF: data = {{16{fill_half}}, raw[31:16]};
            default:   data = raw;
        endcase
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates fetch and data-stage access to one memory unit; grants are combinational, read data returns one cycle after grant.
// No back-pressure; fixed dm priority unless MEM_ARB_ROUND_ROBIN_EN selects alternating priority on contention.
module memory_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic        dm_unsigned,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,

    output logic [4:0]  mem_access_code,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_to_store,
    output logic [1:0]  mem_prev_r,
    input  logic [1:0]  mem_r,
    input  logic [31:0] mem_rdata
);

    logic        dm_win;
    logic        rd_grant;
    logic        rd_pending;
    owner_e      rd_owner;
    logic [1:0]  rd_size;
    logic        rd_unsigned;
    logic [31:0] load_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e last_owner;

    // On contention the requester that did not win last time goes first.
    assign dm_win = dm_req && (!if_req || last_owner == OWNER_IF);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_owner <= OWNER_IF;
        end else if (dm_gnt) begin
            last_owner <= OWNER_DM;
        end else if (if_gnt) begin
            last_owner <= OWNER_IF;
        end
    end
`else
    assign dm_win = dm_req;
`endif

    assign dm_gnt = resetn && dm_win;
    assign if_gnt = resetn && if_req && !dm_win;

    always_comb begin
        mem_access_code   = '0;
        mem_address       = '0;
        mem_data_to_store = '0;
        if (dm_gnt) begin
            mem_access_code[AC_STORE_BIT]         = dm_we;
            mem_access_code[AC_BE_MSB:AC_BE_LSB]  = size_to_be(dm_size);
            mem_address                           = dm_addr;
            if (dm_we) begin
                case (dm_size)
                    SIZE_BYTE: mem_data_to_store = {dm_wdata[7:0], 24'h0};
                    SIZE_HALF: mem_data_to_store = {dm_wdata[15:0], 16'h0};
                    default:   mem_data_to_store = dm_wdata;
                endcase
            end
        end else if (if_gnt) begin
            mem_access_code[AC_BE_MSB:AC_BE_LSB] = BE_WORD;
            mem_address                          = if_addr;
        end
    end

    assign rd_grant = if_gnt || (dm_gnt && !dm_we);

    // A newer read grant overwrites the tracking of the one being returned now.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_pending  <= 1'b0;
            rd_owner    <= OWNER_IF;
            rd_size     <= SIZE_WORD;
            rd_unsigned <= 1'b0;
            mem_prev_r  <= 2'b00;
        end else begin
            rd_pending <= rd_grant;
            if (rd_grant) begin
                rd_owner    <= dm_gnt ? OWNER_DM : OWNER_IF;
                rd_size     <= dm_gnt ? dm_size : SIZE_WORD;
                rd_unsigned <= dm_gnt && dm_unsigned;
                mem_prev_r  <= mem_r;
            end
        end
    end

    mem_load_align u_load_align (
        .raw      (mem_rdata),
        .size     (rd_size),
        .zero_ext (rd_unsigned),
        .data     (load_data)
    );

    assign if_rvalid = rd_pending && (rd_owner == OWNER_IF);
    assign dm_rvalid = rd_pending && (rd_owner == OWNER_DM);
    assign if_rdata  = if_rvalid ? load_data : 32'h0;
    assign dm_rdata  = dm_rvalid ? load_data : 32'h0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a byte-wide synchronous memory model
// (byte at the access address lands in [31:24], addresses wrap at 256 KiB).
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic        dm_unsigned;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [4:0]  mem_access_code;
    logic [31:0] mem_address;
    logic [31:0] mem_data_to_store;
    logic [1:0]  mem_prev_r;
    logic [1:0]  mem_r;
    logic [31:0] mem_rdata = 32'h0;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem_model [0:262143];
    logic [17:0] model_a;

    always #5 clock = ~clock;

    memory_arbiter dut (
        .clock             (clock),
        .resetn            (resetn),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_gnt            (if_gnt),
        .if_rvalid         (if_rvalid),
        .if_rdata          (if_rdata),
        .dm_req            (dm_req),
        .dm_we             (dm_we),
        .dm_size           (dm_size),
        .dm_unsigned       (dm_unsigned),
        .dm_addr           (dm_addr),
        .dm_wdata          (dm_wdata),
        .dm_gnt            (dm_gnt),
        .dm_rvalid         (dm_rvalid),
        .dm_rdata          (dm_rdata),
        .mem_access_code   (mem_access_code),
        .mem_address       (mem_address),
        .mem_data_to_store (mem_data_to_store),
        .mem_prev_r        (mem_prev_r),
        .mem_r             (mem_r),
        .mem_rdata         (mem_rdata)
    );

    assign mem_r = mem_address[1:0];

    always @(posedge clock) begin
        model_a = mem_address[17:0];
        if (mem_access_code[4]) begin
            for (int b = 0; b < 4; b++)
                if (mem_access_code[3-b])
                    mem_model[model_a + 18'(b)] = mem_data_to_store[31-8*b -: 8];
        end else if (mem_access_code[3:0] != 4'h0) begin
            mem_rdata <= {mem_model[model_a], mem_model[model_a + 18'd1],
                          mem_model[model_a + 18'd2], mem_model[model_a + 18'd3]};
        end
    end

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b10; dm_unsigned = 1'b0;
        dm_addr = 32'h0; dm_wdata = 32'h0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h88; dm_req = 1'b1; dm_addr = 32'h44;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL reset_if_gnt got=%b exp=0", if_gnt); end
        checks++; if (dm_gnt !== 1'b0) begin errors++; $display("FAIL reset_dm_gnt got=%b exp=0", dm_gnt); end
        checks++; if (mem_access_code !== 5'h0) begin errors++; $display("FAIL reset_code got=%b exp=00000", mem_access_code); end
        checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
        checks++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", {if_rvalid, dm_rvalid}); end
        checks++; if ({if_rdata, dm_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, dm_rdata}); end
        checks++; if (mem_prev_r !== 2'b00) begin errors++; $display("FAIL reset_prev_r got=%b exp=00", mem_prev_r); end
        @(negedge clock);
        resetn = 1'b1;
        idle_inputs();
    endtask

    task automatic test_contention();
        logic [3:0] exp_dm;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_dm = 4'b0101;
`else
        exp_dm = 4'b1111;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 0) begin
                dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h10;
                if_req = 1'b1; if_addr = 32'h20;
            end
            #1;
            checks++; if ({dm_gnt, if_gnt} !== {exp_dm[i], !exp_dm[i]}) begin errors++; $display("FAIL contention_gnt[%0d] got dm,if=%b%b exp=%b%b", i, dm_gnt, if_gnt, exp_dm[i], !exp_dm[i]); end
            checks++; if (mem_address !== (exp_dm[i] ? 32'h10 : 32'h20)) begin errors++; $display("FAIL contention_addr[%0d] got=%h exp=%h", i, mem_address, exp_dm[i] ? 32'h10 : 32'h20); end
        end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if ({dm_rvalid, if_rvalid} !== {exp_dm[3], !exp_dm[3]}) begin errors++; $display("FAIL contention_rvalid got dm,if=%b%b exp=%b%b", dm_rvalid, if_rvalid, exp_dm[3], !exp_dm[3]); end
        checks++; if ((exp_dm[3] ? dm_rdata : if_rdata) !== (exp_dm[3] ? 32'h10111213 : 32'h20212223)) begin errors++; $display("FAIL contention_rdata got dm=%h if=%h", dm_rdata, if_rdata); end
    endtask

    task automatic test_fetch_stream();
        logic [31:0] words [0:2];
        words[0] = 32'h00010203; words[1] = 32'h04050607; words[2] = 32'h08090A0B;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i < 3) begin if_req = 1'b1; if_addr = 32'(4 * i); end
            else if_req = 1'b0;
            #1;
            if (i < 3) begin
                checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt[%0d] got=%b exp=1", i, if_gnt); end
                checks++; if (mem_address !== 32'(4 * i)) begin errors++; $display("FAIL fetch_addr[%0d] got=%h exp=%h", i, mem_address, 4 * i); end
                checks++; if (mem_access_code !== 5'b01111) begin errors++; $display("FAIL fetch_code[%0d] got=%b exp=01111", i, mem_access_code); end
            end
            checks++; if (if_rvalid !== (i > 0)) begin errors++; $display("FAIL fetch_rvalid[%0d] got=%b exp=%b", i, if_rvalid, i > 0); end
            if (i > 0) begin
                checks++; if (if_rdata !== words[i-1]) begin errors++; $display("FAIL fetch_rdata[%0d] got=%h exp=%h", i, if_rdata, words[i-1]); end
                checks++; if ({dm_rvalid, dm_rdata} !== 33'h0) begin errors++; $display("FAIL fetch_dm_quiet[%0d] got rvalid=%b rdata=%h exp 0", i, dm_rvalid, dm_rdata); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_store_load_byte();
        @(negedge clock);
        dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b00; dm_addr = 32'h103; dm_wdata = 32'h123456AB;
        #1;
        checks++; if (dm_gnt !== 1'b1) begin errors++; $display("FAIL sb_gnt got=%b exp=1", dm_gnt); end
        checks++; if (mem_access_code !== 5'b11000) begin errors++; $display("FAIL sb_code got=%b exp=11000", mem_access_code); end
        checks++; if (mem_data_to_store !== 32'hAB000000) begin errors++; $display("FAIL sb_data got=%h exp=AB000000", mem_data_to_store); end
        @(negedge clock);
        dm_we = 1'b0; dm_unsigned = 1'b0; dm_wdata = 32'h0;
        #1;
        checks++; if (mem_access_code !== 5'b01000) begin errors++; $display("FAIL lb_code got=%b exp=01000", mem_access_code); end
        checks++; if (dm_rvalid !== 1'b0) begin errors++; $display("FAIL sb_no_rvalid got=%b exp=0", dm_rvalid); end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if (dm_rvalid !== 1'b1) begin errors++; $display("FAIL lb_rvalid got=%b exp=1", dm_rvalid); end
        checks++; if (dm_rdata !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb_rdata got=%h exp=FFFFFFAB", dm_rdata); end
        checks++; if ({if_rvalid, if_rdata} !== 33'h0) begin errors++; $display("FAIL lb_if_quiet got rvalid=%b rdata=%h exp 0", if_rvalid, if_rdata); end
    endtask

    task automatic test_half_load();
        @(negedge clock);
        dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b01; dm_addr = 32'h202; dm_wdata = 32'hFFFF8001;
        #1;
        checks++; if (mem_access_code !== 5'b11100) begin errors++; $display("FAIL sh_code got=%b exp=11100", mem_access_code); end
        checks++; if (mem_data_to_store !== 32'h80010000) begin errors++; $display("FAIL sh_data got=%h exp=80010000", mem_data_to_store); end
        @(negedge clock);
        dm_we = 1'b0; dm_unsigned = 1'b1; dm_wdata = 32'h0;
        @(negedge clock);
        dm_unsigned = 1'b0;
        #1;
        checks++; if (dm_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_rdata got=%h exp=00008001", dm_rdata); end
        checks++; if (mem_prev_r !== 2'd2) begin errors++; $display("FAIL lhu_prev_r got=%0d exp=2", mem_prev_r); end
        checks++; if (dm_gnt !== 1'b1) begin errors++; $display("FAIL lh_b2b_gnt got=%b exp=1", dm_gnt); end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if ({dm_rvalid, dm_rdata} !== {1'b1, 32'hFFFF8001}) begin errors++; $display("FAIL lh_signed got rvalid=%b rdata=%h exp 1/FFFF8001", dm_rvalid, dm_rdata); end
    endtask

    task automatic test_wrap();
        @(negedge clock);
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b11; dm_addr = 32'h0003FFFF;
        #1;
        checks++; if (mem_address !== 32'h0003FFFF) begin errors++; $display("FAIL wrap_addr got=%h exp=0003FFFF", mem_address); end
        checks++; if (mem_access_code !== 5'b01111) begin errors++; $display("FAIL wrap_code got=%b exp=01111", mem_access_code); end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if (dm_rdata !== 32'hFF000102) begin errors++; $display("FAIL wrap_rdata got=%h exp=FF000102", dm_rdata); end
        checks++; if (mem_prev_r !== 2'd3) begin errors++; $display("FAIL wrap_prev_r got=%0d exp=3", mem_prev_r); end
    endtask

    task automatic test_reset_drop();
        @(negedge clock);
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h4;
        #1;
        checks++; if (dm_gnt !== 1'b1) begin errors++; $display("FAIL drop_gnt got=%b exp=1", dm_gnt); end
        @(negedge clock);
        resetn = 1'b0; if_req = 1'b1; if_addr = 32'h8;
        #1;
        checks++; if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b0000) begin errors++; $display("FAIL drop_rst_flags got=%b exp=0000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid}); end
        checks++; if ({if_rdata, dm_rdata} !== 64'h0) begin errors++; $display("FAIL drop_rst_rdata got=%h exp=0", {if_rdata, dm_rdata}); end
        checks++; if ({mem_access_code, mem_prev_r} !== 7'h0) begin errors++; $display("FAIL drop_rst_code got=%b exp=0", {mem_access_code, mem_prev_r}); end
        @(negedge clock);
        resetn = 1'b1;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            checks++; if ({dm_rvalid, if_rvalid} !== 2'b00) begin errors++; $display("FAIL drop_after[%0d] got=%b exp=00", i, {dm_rvalid, if_rvalid}); end
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) mem_model[i] = i[7:0];
        test_reset();
        test_contention();
        test_fetch_stream();
        test_store_load_byte();
        test_half_load();
        test_wrap();
        test_reset_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
